fifo_tx_credit: RTL and testbench

- Transmit-side FIFO for the SpaceWire link; mirrors the receive FIFO on the opposite end of the link.
- The host writes N-chars in; the TX encoder pops them.
- Tracks the link credit granted by FCTs from the remote receiver. Each received FCT grants 8 credits; each transmitted N-char consumes 1.
- Blocks transmission when credit is 0 and flags credit overflow (> MAX_CREDIT).

---
 rtl/spw_fifo_pkg.sv | 19 +
 rtl/mem_data.sv | 25 ++
 rtl/fifo_tx_credit.sv | 164 ++++++++++++++++
 tb/tb_fifo_tx_credit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spw_fifo_pkg.sv
// Shared types and constants for the SpaceWire FIFO blocks.
// Holds the write/read handshake FSM encodings and the FCT credit constants.
package spw_fifo_pkg;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_HOLD = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_t;

    // One FCT from the remote receiver frees room for eight N-chars.
    localparam int FCT_CREDIT         = 8;
    localparam int MAX_CREDIT_DEFAULT = 56;

endpackage

// File: rtl/mem_data.sv
// Dual-port N-char storage: synchronous write port, combinational read port.
// Contents are not reset; validity is tracked by the FIFO pointers and counter.
module mem_data #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              wr_strobe,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clock) begin
        if (wr_strobe) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_tx_credit.sv
// SpaceWire transmit FIFO with FCT-based link credit tracking.
// Define FIFO_TX_CREDIT_BYPASS_EN to drop the credit logic (loopback / bring-up).
module fifo_tx_credit
    import spw_fifo_pkg::*;
#(
    parameter int DWIDTH     = 9,
    parameter int AWIDTH     = 6,
    parameter int MAX_CREDIT = MAX_CREDIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              fct_received,
    output logic [DWIDTH-1:0] data_out,
    output logic              f_full,
    output logic              f_empty,
    output logic              ready_tx,
    output logic [5:0]        credit_count,
    output logic              credit_error,
    output logic [AWIDTH:0]   counter
);

    localparam int              DEPTH      = 2**AWIDTH;
    localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] CNT_ONE    = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

    wr_state_t         wr_state, wr_state_next;
    rd_state_t         rd_state, rd_state_next;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic              wr_do, rd_do;
    logic [AWIDTH:0]   counter_next;

    mem_data #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem_data (
        .clock     (clock),
        .wr_strobe (wr_do),
        .wr_addr   (wr_ptr),
        .wr_data   (data_in),
        .rd_addr   (rd_ptr),
        .rd_data   (data_out)
    );

    // Both FSMs turn a level request into exactly one transfer per assertion.
    always_comb begin
        wr_state_next = wr_state;
        wr_do         = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (wr_en && !f_full) begin
                    wr_do         = 1'b1;
                    wr_state_next = WR_HOLD;
                end
            end
            WR_HOLD: begin
                if (!wr_en) begin
                    wr_state_next = WR_IDLE;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_do         = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (rd_en && ready_tx) begin
                    rd_do         = 1'b1;
                    rd_state_next = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (!rd_en) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        counter_next = counter;
        case ({wr_do, rd_do})
            2'b10:   counter_next = counter + CNT_ONE;
            2'b01:   counter_next = counter - CNT_ONE;
            default: counter_next = counter;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            counter  <= '0;
            f_full   <= 1'b0;
            f_empty  <= 1'b1;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
            if (wr_do) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_do) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            counter <= counter_next;
            f_full  <= (counter_next == FULL_COUNT);
            f_empty <= (counter_next == '0);
        end
    end

`ifdef FIFO_TX_CREDIT_BYPASS_EN

    logic unused_fct;

    assign unused_fct   = fct_received;
    assign credit_count = '0;
    assign credit_error = 1'b0;
    assign ready_tx     = !f_empty;

`else

    localparam logic [6:0] FCT_INC   = 7'(FCT_CREDIT);
    localparam logic [6:0] MAX_LIMIT = 7'(MAX_CREDIT);

    logic [6:0] credit_with_fct;
    logic       fct_overflow;
    logic [5:0] credit_next;

    assign ready_tx = !f_empty && (credit_count != 6'd0);

    // An FCT that would push credit past the limit is dropped; the pop still counts.
    always_comb begin
        credit_with_fct = {1'b0, credit_count} + FCT_INC - {6'd0, rd_do};
        fct_overflow    = fct_received && (credit_with_fct > MAX_LIMIT);
        credit_next     = credit_count - {5'd0, rd_do};
        if (fct_received && !fct_overflow) begin
            credit_next = credit_with_fct[5:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit_count <= '0;
            credit_error <= 1'b0;
        end else begin
            credit_count <= credit_next;
            if (fct_overflow) begin
                credit_error <= 1'b1;
            end
        end
    end

`endif

endmodule

// File: tb/tb_fifo_tx_credit.sv
// Self-checking bench for fifo_tx_credit (default build, credit logic enabled).
// A behavioural model with an N-char scoreboard queue predicts every output.
module tb_fifo_tx_credit;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [8:0] data_in;
    logic       rd_en;
    logic       fct_received;
    logic [8:0] data_out;
    logic       f_full;
    logic       f_empty;
    logic       ready_tx;
    logic [5:0] credit_count;
    logic       credit_error;
    logic [6:0] counter;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    int         m_count;
    int         m_credit;
    logic       m_err;
    logic       m_wr_hold;
    logic       m_rd_hold;

    fifo_tx_credit dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .fct_received (fct_received),
        .data_out     (data_out),
        .f_full       (f_full),
        .f_empty      (f_empty),
        .ready_tx     (ready_tx),
        .credit_count (credit_count),
        .credit_error (credit_error),
        .counter      (counter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        sb.delete();
        m_count   = 0;
        m_credit  = 0;
        m_err     = 1'b0;
        m_wr_hold = 1'b0;
        m_rd_hold = 1'b0;
    endtask

    task automatic checkState();
        checkOutput("counter", 32'(counter), 32'(m_count));
        checkOutput("f_full", 32'(f_full), 32'(m_count == 64));
        checkOutput("f_empty", 32'(f_empty), 32'(m_count == 0));
        checkOutput("credit_count", 32'(credit_count), 32'(m_credit));
        checkOutput("credit_error", 32'(credit_error), 32'(m_err));
        checkOutput("ready_tx", 32'(ready_tx), 32'((m_count != 0) && (m_credit != 0)));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic applyStimulus(input logic wr, input logic [8:0] din, input logic rd, input logic fct);
        logic       do_wr;
        logic       do_rd;
        logic [8:0] exp_data;
        int         c;
        wr_en        = wr;
        data_in      = din;
        rd_en        = rd;
        fct_received = fct;
        do_wr = !m_wr_hold && wr && (m_count < 64);
        do_rd = !m_rd_hold && rd && (m_count != 0) && (m_credit != 0);
        if (do_rd) begin
            exp_data = sb.pop_front();
            checkOutput("pop_data", 32'(data_out), 32'(exp_data));
        end
        if (do_wr) begin
            sb.push_back(din);
        end
        m_count = m_count + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
        c = m_credit - (do_rd ? 1 : 0);
        if (fct) begin
            if (c + 8 > 56) m_err = 1'b1;
            else            c = c + 8;
        end
        m_credit  = c;
        m_wr_hold = m_wr_hold ? wr : do_wr;
        m_rd_hold = m_rd_hold ? rd : do_rd;
        @(posedge clock);
        #1;
        checkState();
    endtask

    task automatic writeChar(input logic [8:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
        applyStimulus(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic popChar();
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic fctPulse();
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        fct_received = 1'b0;
        data_in      = '0;
        reset        = 1'b0;
        modelReset();
        @(posedge clock);
        #1;
        checkState();
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        fct_received = 1'b0;
        data_in      = '0;
        modelReset();

        // Writes with no credit: pops are refused and the head holds.
        doReset();
        writeChar(9'h041);
        writeChar(9'h042);
        writeChar(9'h100);
        popChar();
        popChar();
        checkOutput("head_blocked", 32'(data_out), 32'h041);

        // One FCT, then drain in order.
        fctPulse();
        checkOutput("credit_after_fct", 32'(credit_count), 32'd8);
        popChar();
        popChar();
        popChar();
        checkOutput("credit_after_pops", 32'(credit_count), 32'd5);

        // Fill to 64, drop the 65th, drain across the pointer wrap.
        for (int i = 0; i < 64; i++) begin
            writeChar(9'(i * 7 + 9'h0A5));
        end
        checkOutput("full_count", 32'(counter), 32'd64);
        writeChar(9'h1FF);
        for (int i = 0; i < 64; i++) begin
            if (m_credit == 0) fctPulse();
            popChar();
        end

        // Credit ceiling and sticky overflow.
        doReset();
        for (int i = 0; i < 7; i++) fctPulse();
        checkOutput("credit_max", 32'(credit_count), 32'd56);
        fctPulse();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput("credit_error_sticky", 32'(credit_error), 32'd1);

        // Simultaneous FCT + pop at credit 1, then simultaneous write + pop.
        doReset();
        for (int i = 0; i < 8; i++) writeChar(9'(9'h010 + i));
        fctPulse();
        for (int i = 0; i < 7; i++) popChar();
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput("fct_and_pop", 32'(credit_count), 32'd8);
        writeChar(9'h0C3);
        applyStimulus(1'b1, 9'h0C4, 1'b1, 1'b0);
        checkOutput("wr_and_pop", 32'(counter), 32'd1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);

        // Asynchronous reset mid-operation with the read FSM holding.
        doReset();
        for (int i = 0; i < 14; i++) writeChar(9'(9'h080 + i));
        for (int i = 0; i < 3; i++) fctPulse();
        for (int i = 0; i < 3; i++) popChar();
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
        checkOutput("pre_reset_counter", 32'(counter), 32'd10);
        checkOutput("pre_reset_credit", 32'(credit_count), 32'd20);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_counter", 32'(counter), 32'd0);
        checkOutput("async_credit", 32'(credit_count), 32'd0);
        checkOutput("async_empty", 32'(f_empty), 32'd1);
        checkOutput("async_full", 32'(f_full), 32'd0);
        checkOutput("async_ready", 32'(ready_tx), 32'd0);
        checkOutput("async_error", 32'(credit_error), 32'd0);
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        // rd_en is still high: the read FSM must be back in idle and pop once credit arrives.
        applyStimulus(1'b1, 9'h055, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
        checkOutput("post_reset_pop", 32'(counter), 32'd0);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
